// File: rtl/sr_nl_ce_pkg.sv
`timescale 1ns/1ps
// Shared constants and operation decode for the sr_nl_ce shift register.
// Direction and redundancy selectors are plain ints so they can feed module parameters.
package sr_nl_ce_pkg;

  localparam int SHIFT_LEFT  = 1;
  localparam int SHIFT_RIGHT = 0;
  localparam int TMR_OFF     = 0;
  localparam int TMR_ON      = 1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SHIFT = 2'd2
  } op_e;

  // Load wins over shift; nothing happens without the clock enable.
  function automatic op_e decode_op(input logic ce, input logic l);
    if (!ce) return OP_HOLD;
    if (l) return OP_LOAD;
    return OP_SHIFT;
  endfunction

endpackage

// File: rtl/sr_nl_ce_vote3.sv
`timescale 1ns/1ps
// Bitwise 2-of-3 majority voter used to merge the redundant register copies.
// Purely combinational, zero latency, no flow control.
module tmr_vote3 #(
  parameter int Width = 16
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic [Width-1:0] i_c,
  output logic [Width-1:0] o_y
);

  assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/sr_nl_ce.sv
`timescale 1ns/1ps
// Loadable shift register with clock enable and optional triple-redundant storage; Q updates one C edge after inputs are sampled.
// Async CLR clears all copies; no backpressure. Define SR_NL_CE_ASSERT_EN for simulation checks.
module sr_nl_ce
  import sr_nl_ce_pkg::*;
#(
  parameter int Width = 16,
  parameter int Left  = SHIFT_LEFT,
  parameter int TMR   = TMR_OFF
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             L,
  input  logic             SI,
  input  logic [Width-1:0] D,
  output logic [Width-1:0] Q
);

  op_e w_op;
  assign w_op = decode_op(CE, L);

  // Each copy advances from its own value, so a corrupted copy stays wrong until a load.
  function automatic logic [Width-1:0] f_next(input logic [Width-1:0] cur, input op_e op,
                                              input logic si, input logic [Width-1:0] d);
    logic [Width-1:0] nxt;
    nxt = cur;
    unique case (op)
      OP_LOAD:  nxt = d;
      OP_SHIFT: nxt = (Left == SHIFT_LEFT) ? ((cur << 1) | Width'(si))
                                           : ((cur >> 1) | (Width'(si) << (Width - 1)));
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

  if (TMR == TMR_ON) begin : g_tmr
    (* keep = "true", dont_touch = "true", syn_preserve = 1 *) logic [Width-1:0] r0;
    (* keep = "true", dont_touch = "true", syn_preserve = 1 *) logic [Width-1:0] r1;
    (* keep = "true", dont_touch = "true", syn_preserve = 1 *) logic [Width-1:0] r2;
    logic [Width-1:0] w_vote;

    always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
        r0 <= '0;
        r1 <= '0;
        r2 <= '0;
      end else begin
        r0 <= f_next(r0, w_op, SI, D);
        r1 <= f_next(r1, w_op, SI, D);
        r2 <= f_next(r2, w_op, SI, D);
      end
    end

    tmr_vote3 #(.Width(Width)) u_vote (
      .i_a (r0),
      .i_b (r1),
      .i_c (r2),
      .o_y (w_vote)
    );
    assign Q = w_vote;

`ifdef SR_NL_CE_ASSERT_EN
    always @(posedge C) begin
      if (!CLR && (r0 !== r1 || r1 !== r2))
        $warning("sr_nl_ce: redundant copies disagree r0=%h r1=%h r2=%h", r0, r1, r2);
    end
`endif
  end else begin : g_single
    logic [Width-1:0] r_q;

    always_ff @(posedge C or posedge CLR) begin
      if (CLR) r_q <= '0;
      else     r_q <= f_next(r_q, w_op, SI, D);
    end
    assign Q = r_q;
  end

`ifdef SR_NL_CE_ASSERT_EN
  always @(posedge C) begin
    if (Width < 1 || Width > 64)
      $error("sr_nl_ce: Width=%0d outside 1..64", Width);
    if ((Left != SHIFT_LEFT && Left != SHIFT_RIGHT) || (TMR != TMR_OFF && TMR != TMR_ON))
      $error("sr_nl_ce: illegal Left=%0d or TMR=%0d", Left, TMR);
    if (!CLR && $isunknown({CE, L, SI}))
      $error("sr_nl_ce: unknown control CE=%b L=%b SI=%b", CE, L, SI);
  end
`endif

endmodule

// File: tb/tb_sr_nl_ce.sv
`timescale 1ns/1ps
// Scoreboard bench driving five sr_nl_ce configurations from one shared stimulus stream.
module tb_sr_nl_ce;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        ce  = 1'b0;
  logic        l   = 1'b0;
  logic        si  = 1'b0;
  logic [15:0] d   = '0;

  logic [15:0] q_l16, q_r16, q_tmr;
  logic [7:0]  q_l8;
  logic [0:0]  q_w1;

  always #5 clk = ~clk;

  sr_nl_ce #(.Width(16), .Left(1), .TMR(0)) u_l16 (.C(clk), .CLR(clr), .CE(ce), .L(l), .SI(si), .D(d),      .Q(q_l16));
  sr_nl_ce #(.Width(16), .Left(0), .TMR(0)) u_r16 (.C(clk), .CLR(clr), .CE(ce), .L(l), .SI(si), .D(d),      .Q(q_r16));
  sr_nl_ce #(.Width(8),  .Left(1), .TMR(0)) u_l8  (.C(clk), .CLR(clr), .CE(ce), .L(l), .SI(si), .D(d[7:0]), .Q(q_l8));
  sr_nl_ce #(.Width(1),  .Left(0), .TMR(0)) u_w1  (.C(clk), .CLR(clr), .CE(ce), .L(l), .SI(si), .D(d[0:0]), .Q(q_w1));
  sr_nl_ce #(.Width(16), .Left(1), .TMR(1)) u_tmr (.C(clk), .CLR(clr), .CE(ce), .L(l), .SI(si), .D(d),      .Q(q_tmr));

  typedef struct {
    logic [15:0] l16;
    logic [15:0] r16;
    logic [7:0]  l8;
    logic        w1;
    logic [15:0] tmr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;
  logic [63:0] m_l16, m_r16, m_l8, m_w1, m_tmr;

  // Bit-by-bit reference: each bit takes its neighbour toward the serial input end.
  function automatic logic [63:0] f_model(input logic [63:0] cur, input int w, input bit left,
                                          input logic ce_v, input logic l_v, input logic si_v,
                                          input logic [63:0] d_v);
    logic [63:0] nxt;
    nxt = '0;
    if (!ce_v) return cur;
    for (int i = 0; i < w; i++) begin
      if (l_v)       nxt[i] = d_v[i];
      else if (left) nxt[i] = (i == 0) ? si_v : cur[i-1];
      else           nxt[i] = (i == w - 1) ? si_v : cur[i+1];
    end
    return nxt;
  endfunction

  task automatic model_reset();
    m_l16 = '0; m_r16 = '0; m_l8 = '0; m_w1 = '0; m_tmr = '0;
    sb.delete();
  endtask

  task automatic model_push(input logic ce_v, input logic l_v, input logic si_v, input logic [15:0] d_v);
    exp_t x;
    m_l16 = f_model(m_l16, 16, 1'b1, ce_v, l_v, si_v, {48'd0, d_v});
    m_r16 = f_model(m_r16, 16, 1'b0, ce_v, l_v, si_v, {48'd0, d_v});
    m_l8  = f_model(m_l8,   8, 1'b1, ce_v, l_v, si_v, {48'd0, d_v});
    m_w1  = f_model(m_w1,   1, 1'b0, ce_v, l_v, si_v, {48'd0, d_v});
    m_tmr = f_model(m_tmr, 16, 1'b1, ce_v, l_v, si_v, {48'd0, d_v});
    x.l16 = m_l16[15:0]; x.r16 = m_r16[15:0]; x.l8 = m_l8[7:0]; x.w1 = m_w1[0]; x.tmr = m_tmr[15:0];
    sb.push_back(x);
  endtask

  // Apply inputs at the falling edge, record the expectation, then land just after the rising edge.
  task automatic drive(input logic ce_v, input logic l_v, input logic si_v, input logic [15:0] d_v);
    @(negedge clk);
    ce = ce_v; l = l_v; si = si_v; d = d_v;
    model_push(ce_v, l_v, si_v, d_v);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      e = '{default: '0};
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b1; l = 1'b1; d = 16'hFFFF;
    model_reset();
    #1;
    n_chk++; if (q_l16 !== 16'h0) begin n_err++; $display("FAIL reset_l16: got %h want 0000", q_l16); end
    n_chk++; if (q_r16 !== 16'h0) begin n_err++; $display("FAIL reset_r16: got %h want 0000", q_r16); end
    n_chk++; if (q_l8 !== 8'h0)   begin n_err++; $display("FAIL reset_l8: got %h want 00", q_l8); end
    n_chk++; if (q_w1 !== 1'b0)   begin n_err++; $display("FAIL reset_w1: got %b want 0", q_w1); end
    @(posedge clk); #1;
    n_chk++; if (q_tmr !== 16'h0) begin n_err++; $display("FAIL reset_hold_tmr: got %h want 0000", q_tmr); end
    @(negedge clk);
    ce = 1'b0; l = 1'b0; clr = 1'b0;
  endtask

  task automatic test_load_shift_left();
    drive(1'b1, 1'b1, 1'b0, 16'hA5C3);
    pop_exp();
    n_chk++; if (q_l16 !== e.l16)    begin n_err++; $display("FAIL load_l16: got %h want %h", q_l16, e.l16); end
    n_chk++; if (q_l16 !== 16'hA5C3) begin n_err++; $display("FAIL load_l16_const: got %h want a5c3", q_l16); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h0000);
      pop_exp();
      n_chk++; if (q_l16 !== e.l16) begin n_err++; $display("FAIL shl_l16[%0d]: got %h want %h", i, q_l16, e.l16); end
      n_chk++; if (q_tmr !== e.tmr) begin n_err++; $display("FAIL shl_tmr[%0d]: got %h want %h", i, q_tmr, e.tmr); end
    end
    n_chk++; if (q_l16 !== 16'h5C3F) begin n_err++; $display("FAIL shl_l16_const: got %h want 5c3f", q_l16); end
  endtask

  task automatic test_shift_right();
    drive(1'b1, 1'b1, 1'b0, 16'h8001);
    pop_exp();
    n_chk++; if (q_r16 !== e.r16) begin n_err++; $display("FAIL load_r16: got %h want %h", q_r16, e.r16); end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    pop_exp();
    n_chk++; if (q_r16 !== e.r16)    begin n_err++; $display("FAIL shr0_r16: got %h want %h", q_r16, e.r16); end
    n_chk++; if (q_r16 !== 16'h4000) begin n_err++; $display("FAIL shr0_r16_const: got %h want 4000", q_r16); end
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    pop_exp();
    n_chk++; if (q_r16 !== 16'hA000) begin n_err++; $display("FAIL shr1_r16_const: got %h want a000", q_r16); end
    n_chk++; if (q_w1 !== e.w1)      begin n_err++; $display("FAIL shr1_w1: got %b want %b", q_w1, e.w1); end
  endtask

  task automatic test_ce_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'hFFFF);
      pop_exp();
      n_chk++; if (q_l16 !== e.l16) begin n_err++; $display("FAIL hold_l16[%0d]: got %h want %h", i, q_l16, e.l16); end
      n_chk++; if (q_r16 !== e.r16) begin n_err++; $display("FAIL hold_r16[%0d]: got %h want %h", i, q_r16, e.r16); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, i[0], 16'hFFFF);
      pop_exp();
      n_chk++; if (q_l16 !== e.l16) begin n_err++; $display("FAIL ce_shift_l16[%0d]: got %h want %h", i, q_l16, e.l16); end
      n_chk++; if (q_r16 !== e.r16) begin n_err++; $display("FAIL ce_shift_r16[%0d]: got %h want %h", i, q_r16, e.r16); end
    end
  endtask

  task automatic test_async_clr();
    drive(1'b1, 1'b1, 1'b0, 16'h1234);
    pop_exp();
    n_chk++; if (q_l16 !== 16'h1234) begin n_err++; $display("FAIL pre_clr_l16: got %h want 1234", q_l16); end
    #2 clr = 1'b1;
    model_reset();
    #1;
    n_chk++; if (q_l16 !== 16'h0) begin n_err++; $display("FAIL clr_now_l16: got %h want 0000", q_l16); end
    n_chk++; if (q_tmr !== 16'h0) begin n_err++; $display("FAIL clr_now_tmr: got %h want 0000", q_tmr); end
    @(negedge clk);
    ce = 1'b1; l = 1'b1; d = 16'hFFFF;
    @(posedge clk); #1;
    n_chk++; if (q_l16 !== 16'h0) begin n_err++; $display("FAIL clr_held_l16: got %h want 0000", q_l16); end
    @(negedge clk);
    d = 16'h00FF;
    #1 clr = 1'b0;
    model_push(1'b1, 1'b1, 1'b0, 16'h00FF);
    @(posedge clk); #1;
    pop_exp();
    n_chk++; if (q_l16 !== 16'h00FF) begin n_err++; $display("FAIL clr_release_l16: got %h want 00ff", q_l16); end
    n_chk++; if (q_tmr !== e.tmr)    begin n_err++; $display("FAIL clr_release_tmr: got %h want %h", q_tmr, e.tmr); end
    n_chk++; if (q_l8 !== e.l8)      begin n_err++; $display("FAIL clr_release_l8: got %h want %h", q_l8, e.l8); end
  endtask

  task automatic test_width_edges();
    drive(1'b1, 1'b1, 1'b0, 16'h0080);
    pop_exp();
    n_chk++; if (q_l8 !== 8'h80) begin n_err++; $display("FAIL w8_load: got %h want 80", q_l8); end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    pop_exp();
    n_chk++; if (q_l8 !== 8'h00) begin n_err++; $display("FAIL w8_msb_drop: got %h want 00", q_l8); end
    n_chk++; if (q_w1 !== e.w1)  begin n_err++; $display("FAIL w1_shift0: got %b want %b", q_w1, e.w1); end
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    pop_exp();
    n_chk++; if (q_w1 !== 1'b1) begin n_err++; $display("FAIL w1_shift1: got %b want 1", q_w1); end
    n_chk++; if (q_l8 !== e.l8) begin n_err++; $display("FAIL w8_shift1: got %h want %h", q_l8, e.l8); end
  endtask

  task automatic test_tmr();
    drive(1'b1, 1'b1, 1'b0, 16'hF0F0);
    pop_exp();
    n_chk++; if (q_tmr !== 16'hF0F0) begin n_err++; $display("FAIL tmr_load: got %h want f0f0", q_tmr); end
    @(negedge clk);
    ce = 1'b0;
    force u_tmr.g_tmr.r1 = 16'h0F0F;
    #1;
    n_chk++; if (q_tmr !== 16'hF0F0) begin n_err++; $display("FAIL tmr_vote_masks: got %h want f0f0", q_tmr); end
    release u_tmr.g_tmr.r1;
    drive(1'b1, 1'b1, 1'b0, 16'h1111);
    pop_exp();
    n_chk++; if (u_tmr.g_tmr.r0 !== 16'h1111) begin n_err++; $display("FAIL tmr_r0: got %h want 1111", u_tmr.g_tmr.r0); end
    n_chk++; if (u_tmr.g_tmr.r1 !== 16'h1111) begin n_err++; $display("FAIL tmr_r1_rewritten: got %h want 1111", u_tmr.g_tmr.r1); end
    n_chk++; if (u_tmr.g_tmr.r2 !== 16'h1111) begin n_err++; $display("FAIL tmr_r2: got %h want 1111", u_tmr.g_tmr.r2); end
    n_chk++; if (q_tmr !== e.tmr)             begin n_err++; $display("FAIL tmr_q: got %h want %h", q_tmr, e.tmr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 16'($urandom));
      pop_exp();
      n_chk++;
      if (q_l16 !== e.l16 || q_r16 !== e.r16 || q_l8 !== e.l8 || q_w1 !== e.w1 || q_tmr !== e.tmr) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h %h %h %b %h want %h %h %h %b %h", i,
                 q_l16, q_r16, q_l8, q_w1, q_tmr, e.l16, e.r16, e.l8, e.w1, e.tmr);
      end
    end
    n_chk++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_load_shift_left();
    test_shift_right();
    test_ce_hold();
    test_async_clr();
    test_width_edges();
    test_tmr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
